// File: rtl/ps2_kbd_emulator_if.sv
// PS/2 line bundle seen from the keyboard: synchronised-in line levels and open-collector pull-down enables.
interface ps2_kbd_emulator_if;
  logic i_ps2_clk;
  logic i_ps2_data;
  logic o_ps2_clk_oe;
  logic o_ps2_data_oe;

  modport master (
    input  i_ps2_clk,
    input  i_ps2_data,
    output o_ps2_clk_oe,
    output o_ps2_data_oe
  );

  modport slave (
    output i_ps2_clk,
    output i_ps2_data,
    input  o_ps2_clk_oe,
    input  o_ps2_data_oe
  );
endinterface

// File: rtl/ps2_kbd_emulator.sv
// Device-side PS/2 keyboard: turns joypad edges into scancode frames and answers host commands (FF, ED+param).
module ps2_kbd_emulator #(
  parameter int CLK_HALF = 2500,
  parameter int GAP      = 5000,
  parameter int RTS_MIN  = 500
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [9:0]         i_jp_vector,
  ps2_kbd_emulator_if.master ps2,
  output logic               o_cmd_val,
  output logic [7:0]         o_cmd,
  output logic [2:0]         o_leds,
  output logic               o_busy
);
  localparam int MAXC = (GAP > CLK_HALF) ? ((GAP > RTS_MIN) ? GAP : RTS_MIN)
                                         : ((CLK_HALF > RTS_MIN) ? CLK_HALF : RTS_MIN);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] HALF_MID = CW'(CLK_HALF / 2);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
  localparam logic [CW-1:0] RTS_END  = CW'(RTS_MIN - 1);

  typedef enum logic [2:0] {
    IDLE, TX_HIGH, TX_LOW, TX_GAP, RX_LOW, RX_HIGH, RX_ACK_LOW, RX_ACK_HIGH
  } state_t;

  function automatic logic [7:0] scancode(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd9:    c = 8'h1D;
      4'd8:    c = 8'h1B;
      4'd7:    c = 8'h1C;
      4'd6:    c = 8'h23;
      4'd5:    c = 8'h3B;
      4'd4:    c = 8'h42;
      4'd3:    c = 8'h3C;
      4'd2:    c = 8'h43;
      4'd1:    c = 8'h2A;
      default: c = 8'h32;
    endcase
    return c;
  endfunction

  // Queue word is {count[1:0], entry1, entry0}; entry0 is the head. A full queue drops its oldest entry.
  function automatic logic [17:0] q_push(input logic [17:0] st, input logic [7:0] v);
    logic [17:0] r;
    case (st[17:16])
      2'd0:    r = {2'd1, st[15:8], v};
      2'd1:    r = {2'd2, v, st[7:0]};
      default: r = {2'd2, v, st[15:8]};
    endcase
    return r;
  endfunction

  function automatic logic [17:0] q_pop(input logic [17:0] st);
    return {st[17:16] - 2'd1, 8'h00, st[15:8]};
  endfunction

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_s, dat_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [10:0]   frame_q, frame_d;
  logic [9:0]    rx_q, rx_d;
  logic          src_resp_q, src_resp_d;
  logic [3:0]    key_idx_q, key_idx_d;
  logic          key_rel_q, key_rel_d;
  logic          key_phase_q, key_phase_d;
  logic [9:0]    prev_q, prev_d;
  logic [17:0]   queue_q, queue_d;
  logic          expect_q, expect_d;
  logic          cmd_val_q, cmd_val_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [2:0]    leds_q, leds_d;
  logic          clk_oe, data_oe, start_tx;
  logic [7:0]    tx_byte;
  logic [9:0]    diff;
  logic [3:0]    sel_idx;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  always_ff @(posedge i_clk) begin
    frame_q <= frame_d;
    rx_q    <= rx_d;
    if (i_rst) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      src_resp_q  <= 1'b0;
      key_idx_q   <= 4'd0;
      key_rel_q   <= 1'b0;
      key_phase_q <= 1'b0;
      prev_q      <= 10'd0;
      queue_q     <= {2'd1, 8'h00, 8'hAA};
      expect_q    <= 1'b0;
      cmd_val_q   <= 1'b0;
      cmd_q       <= 8'h00;
      leds_q      <= 3'd0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2.i_ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2.i_ps2_data};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      src_resp_q  <= src_resp_d;
      key_idx_q   <= key_idx_d;
      key_rel_q   <= key_rel_d;
      key_phase_q <= key_phase_d;
      prev_q      <= prev_d;
      queue_q     <= queue_d;
      expect_q    <= expect_d;
      cmd_val_q   <= cmd_val_d;
      cmd_q       <= cmd_d;
      leds_q      <= leds_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    src_resp_d  = src_resp_q;
    key_idx_d   = key_idx_q;
    key_rel_d   = key_rel_q;
    key_phase_d = key_phase_q;
    prev_d      = prev_q;
    queue_d     = queue_q;
    expect_d    = expect_q;
    cmd_val_d   = 1'b0;
    cmd_d       = cmd_q;
    leds_d      = leds_q;
    clk_oe      = 1'b0;
    data_oe     = 1'b0;
    start_tx    = 1'b0;
    tx_byte     = 8'h00;
    diff        = i_jp_vector ^ prev_q;
    sel_idx     = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (diff[i]) sel_idx = 4'(i);
    end

    case (state_q)
      IDLE: begin
        if (clk_s && !dat_s) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == RTS_END) begin
            state_d     = RX_LOW;
            cnt_d       = '0;
            bit_d       = 4'd0;
            key_phase_d = 1'b0;
          end
        end else begin
          cnt_d = '0;
          // Only start a frame on an idle bus, never while the host inhibits the clock.
          if (clk_s) begin
            if (queue_q[17:16] != 2'd0) begin
              start_tx   = 1'b1;
              tx_byte    = queue_q[7:0];
              src_resp_d = 1'b1;
            end else if (key_phase_q) begin
              start_tx   = 1'b1;
              tx_byte    = scancode(key_idx_q);
              src_resp_d = 1'b0;
            end else if (diff != 10'd0) begin
              start_tx   = 1'b1;
              src_resp_d = 1'b0;
              key_idx_d  = sel_idx;
              key_rel_d  = ~i_jp_vector[sel_idx];
              tx_byte    = key_rel_d ? 8'hF0 : scancode(sel_idx);
            end
          end
          if (start_tx) begin
            frame_d = {1'b1, ~^tx_byte, tx_byte, 1'b0};
            state_d = TX_HIGH;
            bit_d   = 4'd0;
          end
        end
      end
      TX_HIGH: begin
        data_oe = ~frame_q[bit_q];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = clk_s ? TX_LOW : IDLE;
          if (!clk_s) bit_d = 4'd0;
        end
      end
      TX_LOW: begin
        clk_oe  = 1'b1;
        data_oe = ~frame_q[bit_q];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (bit_q == 4'd10) begin
            state_d = TX_GAP;
            if (src_resp_q) begin
              queue_d = q_pop(queue_q);
            end else if (key_rel_q && !key_phase_q) begin
              key_phase_d = 1'b1;
            end else begin
              prev_d[key_idx_q] = ~key_rel_q;
              key_phase_d       = 1'b0;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = TX_HIGH;
          end
        end
      end
      TX_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      RX_LOW: begin
        clk_oe = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = RX_HIGH;
        end
      end
      RX_HIGH: begin
        if (cnt_q == HALF_MID) rx_d[bit_q] = dat_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            state_d = RX_ACK_LOW;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = RX_LOW;
          end
        end
      end
      RX_ACK_LOW: begin
        clk_oe  = 1'b1;
        data_oe = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = RX_ACK_HIGH;
        end
      end
      default: begin
        data_oe = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          // rx_q = {stop, parity, D7..D0}
          if ((rx_q[8] != ~^rx_q[7:0]) || !rx_q[9]) begin
            queue_d = q_push(queue_q, 8'hFE);
          end else begin
            cmd_val_d = 1'b1;
            cmd_d     = rx_q[7:0];
            if (rx_q[7:0] == 8'hFF) begin
              queue_d = q_push(q_push(queue_q, 8'hFA), 8'hAA);
            end else if (rx_q[7:0] == 8'hED) begin
              queue_d  = q_push(queue_q, 8'hFA);
              expect_d = 1'b1;
            end else begin
              if (expect_q) begin
                leds_d   = rx_q[2:0];
                expect_d = 1'b0;
              end
              queue_d = q_push(queue_q, 8'hFA);
            end
          end
        end
      end
    endcase
  end

  assign ps2.o_ps2_clk_oe  = clk_oe;
  assign ps2.o_ps2_data_oe = data_oe;
  assign o_cmd_val         = cmd_val_q;
  assign o_cmd             = cmd_q;
  assign o_leds            = leds_q;
  assign o_busy            = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_kbd_emulator.sv
// Directed bench for ps2_kbd_emulator: host-side line model, frame capture and host command injection.
module tb_ps2_kbd_emulator;
  localparam int CLK_HALF = 8;
  localparam int GAP      = 40;
  localparam int RTS_MIN  = 12;
  localparam int BOUND    = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] jp = 10'd0;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;
  logic       cmd_val;
  logic [7:0] cmd;
  logic [2:0] leds;
  logic       busy;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         cmd_cnt = 0;
  logic [7:0] last_cmd = 8'h00;

  ps2_kbd_emulator_if bus();
  assign bus.i_ps2_clk  = ~(bus.o_ps2_clk_oe | host_clk_low);
  assign bus.i_ps2_data = ~(bus.o_ps2_data_oe | host_data_low);

  ps2_kbd_emulator #(.CLK_HALF(CLK_HALF), .GAP(GAP), .RTS_MIN(RTS_MIN)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_jp_vector (jp),
    .ps2         (bus),
    .o_cmd_val   (cmd_val),
    .o_cmd       (cmd),
    .o_leds      (leds),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_val) begin
      cmd_cnt  <= cmd_cnt + 1;
      last_cmd <= cmd;
    end
  end

  function automatic logic [10:0] frm(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    repeat (2 * CLK_HALF + GAP + 6) step();
  endtask

  // Collect one 11-bit frame, sampling data on each falling edge of the clock line.
  task automatic capture(output logic [10:0] f, output int t_first, output int t_last, output bit to);
    int   n;
    int   waited;
    logic prev;
    n = 0; waited = 0; f = '0; to = 1'b0; t_first = 0; t_last = 0;
    prev = bus.i_ps2_clk;
    while (n < 11 && !to) begin
      step();
      waited++;
      if (prev && !bus.i_ps2_clk) begin
        f[n] = bus.i_ps2_data;
        if (n == 0) t_first = cyc;
        t_last = cyc;
        n++;
      end
      prev = bus.i_ps2_clk;
      if (waited > BOUND) to = 1'b1;
    end
  endtask

  // Host request-to-send, then shift out bits on the device's falling edges; the 11th clock carries the ack.
  task automatic host_send(input logic [7:0] b, input bit bad_par, output bit ack_ok, output bit to);
    logic [10:0] bits;
    int          n;
    int          waited;
    logic        prev;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    n = 0; waited = 0; ack_ok = 1'b0; to = 1'b0;
    host_data_low = 1'b1;
    prev = bus.i_ps2_clk;
    while (n < 11 && !to) begin
      step();
      waited++;
      if (prev && !bus.i_ps2_clk) begin
        n++;
        if (n <= 10) host_data_low = ~bits[n];
        else ack_ok = bus.o_ps2_data_oe && !bus.i_ps2_data;
      end
      prev = bus.i_ps2_clk;
      if (waited > BOUND) to = 1'b1;
    end
    host_data_low = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] f;
    int tf, tl;
    bit to;
    rst = 1'b1;
    repeat (3) step();
    tests++;
    if ({busy, cmd_val, cmd, leds, bus.o_ps2_clk_oe, bus.o_ps2_data_oe} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, cmd_val, cmd, leds, bus.o_ps2_clk_oe, bus.o_ps2_data_oe});
    end
    rst = 1'b0;
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== 11'b111_0101_0100) begin
      fails++;
      $display("FAIL bat_frame: got %b (timeout %0d) expected %b", f, to, 11'b111_0101_0100);
    end
    idle_wait();
    tests++;
    if ({busy, bus.o_ps2_clk_oe, bus.o_ps2_data_oe} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_bat: got %b expected 000", {busy, bus.o_ps2_clk_oe, bus.o_ps2_data_oe});
    end
  endtask

  task automatic test_press_release();
    logic [10:0] f;
    int tf, tl, t_f0_end;
    bit to;
    jp[9] = 1'b1;
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== frm(8'h1D)) begin
      fails++;
      $display("FAIL up_press: got %b expected %b", f, frm(8'h1D));
    end
    idle_wait();
    jp[9] = 1'b0;
    capture(f, tf, t_f0_end, to);
    tests++;
    if (to || f !== frm(8'hF0)) begin
      fails++;
      $display("FAIL up_release_f0: got %b expected %b", f, frm(8'hF0));
    end
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== frm(8'h1D)) begin
      fails++;
      $display("FAIL up_release_code: got %b expected %b", f, frm(8'h1D));
    end
    tests++;
    if (tf - t_f0_end < GAP) begin
      fails++;
      $display("FAIL release_gap: got %0d cycles expected >= %0d", tf - t_f0_end, GAP);
    end
    idle_wait();
  endtask

  task automatic test_simultaneous();
    logic [7:0]  press_exp [2] = '{8'h23, 8'h32};
    logic [7:0]  rel_exp   [4] = '{8'hF0, 8'h23, 8'hF0, 8'h32};
    logic [10:0] f;
    int tf, tl;
    bit to;
    jp[6] = 1'b1;
    jp[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      capture(f, tf, tl, to);
      tests++;
      if (to || f !== frm(press_exp[i])) begin
        fails++;
        $display("FAIL simul_press[%0d]: got %b expected %b", i, f, frm(press_exp[i]));
      end
    end
    idle_wait();
    jp[6] = 1'b0;
    jp[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      capture(f, tf, tl, to);
      tests++;
      if (to || f !== frm(rel_exp[i])) begin
        fails++;
        $display("FAIL simul_release[%0d]: got %b expected %b", i, f, frm(rel_exp[i]));
      end
    end
    idle_wait();
  endtask

  task automatic test_host_leds();
    logic [10:0] f;
    int tf, tl, base;
    bit ack, to;
    base = cmd_cnt;
    host_send(8'hED, 1'b0, ack, to);
    tests++;
    if (to || !ack) begin
      fails++;
      $display("FAIL ed_ack: got ack=%0d timeout=%0d expected ack=1 timeout=0", ack, to);
    end
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== frm(8'hFA)) begin
      fails++;
      $display("FAIL ed_reply: got %b expected %b", f, frm(8'hFA));
    end
    tests++;
    if (cmd_cnt != base + 1 || last_cmd !== 8'hED) begin
      fails++;
      $display("FAIL ed_cmd: got %0d pulses cmd %h expected %0d pulses cmd ed", cmd_cnt - base, last_cmd, 1);
    end
    host_send(8'h05, 1'b0, ack, to);
    tests++;
    if (to || !ack) begin
      fails++;
      $display("FAIL param_ack: got ack=%0d timeout=%0d expected ack=1 timeout=0", ack, to);
    end
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== frm(8'hFA)) begin
      fails++;
      $display("FAIL param_reply: got %b expected %b", f, frm(8'hFA));
    end
    tests++;
    if (cmd_cnt != base + 2 || last_cmd !== 8'h05) begin
      fails++;
      $display("FAIL param_cmd: got %0d pulses cmd %h expected 2 pulses cmd 05", cmd_cnt - base, last_cmd);
    end
    tests++;
    if (leds !== 3'b101) begin
      fails++;
      $display("FAIL leds: got %b expected 101", leds);
    end
    idle_wait();
  endtask

  task automatic test_bad_parity();
    logic [10:0] f;
    int tf, tl, base;
    bit ack, to;
    base = cmd_cnt;
    host_send(8'hFF, 1'b1, ack, to);
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== frm(8'hFE)) begin
      fails++;
      $display("FAIL bad_parity_reply: got %b expected %b", f, frm(8'hFE));
    end
    tests++;
    if (cmd_cnt != base) begin
      fails++;
      $display("FAIL bad_parity_cmd_val: got %0d pulses expected 0", cmd_cnt - base);
    end
    idle_wait();
    host_send(8'hFF, 1'b0, ack, to);
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== frm(8'hFA)) begin
      fails++;
      $display("FAIL reset_cmd_fa: got %b expected %b", f, frm(8'hFA));
    end
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== frm(8'hAA)) begin
      fails++;
      $display("FAIL reset_cmd_aa: got %b expected %b", f, frm(8'hAA));
    end
    tests++;
    if (cmd_cnt != base + 1 || last_cmd !== 8'hFF) begin
      fails++;
      $display("FAIL reset_cmd: got %0d pulses cmd %h expected 1 pulse cmd ff", cmd_cnt - base, last_cmd);
    end
    idle_wait();
  endtask

  task automatic test_inhibit();
    logic [10:0] f;
    int tf, tl, n, waited;
    bit to, rel_ok, found;
    logic prev;
    jp[4] = 1'b1;
    n = 0; waited = 0; found = 1'b0;
    prev = bus.i_ps2_clk;
    while (!found && waited < BOUND) begin
      step();
      waited++;
      if (prev && !bus.i_ps2_clk) n++;
      if (n == 4 && !prev && bus.i_ps2_clk) found = 1'b1;
      prev = bus.i_ps2_clk;
    end
    host_clk_low = 1'b1;
    rel_ok = 1'b0;
    for (int i = 0; i < CLK_HALF + 3 && !rel_ok; i++) begin
      step();
      if (!bus.o_ps2_clk_oe && !bus.o_ps2_data_oe) rel_ok = 1'b1;
    end
    tests++;
    if (!found || !rel_ok) begin
      fails++;
      $display("FAIL inhibit_release: got found=%0d released=%0d expected 1 1", found, rel_ok);
    end
    repeat (30) step();
    tests++;
    if ({busy, bus.o_ps2_clk_oe, bus.o_ps2_data_oe} !== 3'b000) begin
      fails++;
      $display("FAIL inhibit_hold: got %b expected 000", {busy, bus.o_ps2_clk_oe, bus.o_ps2_data_oe});
    end
    host_clk_low = 1'b0;
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== frm(8'h42)) begin
      fails++;
      $display("FAIL inhibit_retx: got %b expected %b", f, frm(8'h42));
    end
    idle_wait();
  endtask

  task automatic test_mid_reset();
    logic [10:0] f;
    int tf, tl, n, waited;
    bit to;
    logic prev;
    jp[4] = 1'b0;
    n = 0; waited = 0;
    prev = bus.i_ps2_clk;
    while (n < 3 && waited < BOUND) begin
      step();
      waited++;
      if (prev && !bus.i_ps2_clk) n++;
      prev = bus.i_ps2_clk;
    end
    rst = 1'b1;
    step();
    tests++;
    if (n != 3 || {busy, bus.o_ps2_clk_oe, bus.o_ps2_data_oe} !== 3'b000) begin
      fails++;
      $display("FAIL mid_reset_release: got edges=%0d lines=%b expected edges=3 lines=000",
               n, {busy, bus.o_ps2_clk_oe, bus.o_ps2_data_oe});
    end
    rst = 1'b0;
    capture(f, tf, tl, to);
    tests++;
    if (to || f !== frm(8'hAA)) begin
      fails++;
      $display("FAIL mid_reset_bat: got %b expected %b", f, frm(8'hAA));
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_simultaneous();
    test_host_leds();
    test_bad_parity();
    test_inhibit();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
